// File: rtl/z80_io_pkg.sv
// rtl/z80_io_pkg.sv - shared types, register offsets and status layout for the Z80 I/O responder
package z80_io_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    ACC  = 3'd2,
    HOLD = 3'd3,
    INTA = 3'd4
  } state_t;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_INT_PEND = 2;
  localparam int STAT_OVF      = 3;

  function automatic logic [7:0] pack_status(input logic ovf, input logic int_pend,
                                              input logic tx_full, input logic rx_avail);
    logic [7:0] s;
    s = '0;
    s[STAT_OVF]      = ovf;
    s[STAT_INT_PEND] = int_pend;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_RX_AVAIL] = rx_avail;
    return s;
  endfunction

endpackage

// File: rtl/z80_io_fifo.sv
// rtl/z80_io_fifo.sv - synchronous FIFO with wrap-bit pointers, used for the TX path
module z80_io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A push into a full FIFO still lands when the head is consumed in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/z80_io_responder.sv
// rtl/z80_io_responder.sv - Z80 I/O port target with TX FIFO, RX holding reg, wait states and IM2 vector
module z80_io_responder
  import z80_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] IM2_VECTOR  = 8'hE0
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  output logic        WAIT_L,
  output logic        INT_L,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] WAIT_LAST = 8'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state;
  logic        acc_rd, acc_reg, had_data, drive;
  logic [7:0]  dout, wcnt;
  logic        rx_avail, rx_int_en, ovf;
  logic [7:0]  rx_hold;
  logic        tx_full;
  logic [CW-1:0] tx_count;
  logic        sel, inta_cyc, in_acc;
  logic        tx_push, tx_pop, tx_drop, ctrl_wr, rx_pop, rx_load, ovf_clr;
  logic [7:0]  read_val;
  logic        unused_addr;

  assign unused_addr = ^addr_bus[15:8];

  assign sel      = ~IORQ_L & M1_L & (~RD_L | ~WR_L) & (addr_bus[7:1] == BASE_ADDR[7:1]);
  assign inta_cyc = ~IORQ_L & ~M1_L;

  assign in_acc  = (state == ACC);
  assign tx_push = in_acc & ~acc_rd & (acc_reg == REG_DATA);
  assign ctrl_wr = in_acc & ~acc_rd & (acc_reg == REG_STAT);
  assign rx_pop  = in_acc &  acc_rd & (acc_reg == REG_DATA) & had_data;
  assign ovf_clr = in_acc &  acc_rd & (acc_reg == REG_STAT);
  assign tx_pop  = tx_valid & tx_ready;
  assign tx_drop = tx_push & tx_full & ~tx_pop;

  assign rx_ready = ~rx_avail | rx_pop;
  assign rx_load  = rx_valid & rx_ready;
  assign tx_valid = (tx_count != '0);

  assign read_val = (addr_bus[0] == REG_STAT)
                  ? pack_status(ovf, rx_int_en & rx_avail, tx_full, rx_avail)
                  : (rx_avail ? rx_hold : 8'hFF);

  // Released combinationally the moment IORQ_L rises, independent of the FSM.
  assign data_bus = (drive & ~IORQ_L) ? dout : 8'bz;

  z80_io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_L),
    .push      (tx_push),
    .push_data (data_bus),
    .pop       (tx_ready),
    .pop_data  (tx_data),
    .full      (tx_full),
    .count     (tx_count)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      WAIT_L   <= 1'b1;
      drive    <= 1'b0;
      acc_rd   <= 1'b0;
      acc_reg  <= REG_DATA;
      had_data <= 1'b0;
      dout     <= '0;
      wcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inta_cyc) begin
            state <= INTA;
            dout  <= IM2_VECTOR;
            drive <= 1'b1;
          end else if (sel) begin
            acc_rd   <= ~RD_L;
            acc_reg  <= addr_bus[0];
            had_data <= rx_avail;
            dout     <= read_val;
            drive    <= ~RD_L;
            if (WAIT_STATES == 0) begin
              state <= ACC;
            end else begin
              state  <= WAIT;
              WAIT_L <= 1'b0;
              wcnt   <= WAIT_LAST;
            end
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            state  <= ACC;
            WAIT_L <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ACC:  state <= HOLD;
        INTA: state <= HOLD;
        HOLD: begin
          if (IORQ_L) begin
            state <= IDLE;
            drive <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      rx_avail  <= 1'b0;
      rx_hold   <= '0;
      rx_int_en <= 1'b0;
      ovf       <= 1'b0;
      INT_L     <= 1'b1;
    end else begin
      if (rx_load) begin
        rx_hold  <= rx_data;
        rx_avail <= 1'b1;
      end else if (rx_pop) begin
        rx_avail <= 1'b0;
      end
      if (ctrl_wr) rx_int_en <= data_bus[0];
      if (tx_drop)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      INT_L <= ~(rx_int_en & rx_avail);
    end
  end

endmodule

// File: tb/tb_z80_io_responder.sv
// tb/tb_z80_io_responder.sv - scoreboard bench for z80_io_responder with a queue-based reference model
module tb_z80_io_responder;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst_L;
  logic [15:0] addr_bus;
  wire  [7:0]  data_bus;
  logic        IORQ_L, RD_L, WR_L, M1_L;
  logic        WAIT_L, INT_L;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  logic        tb_drv;
  logic [7:0]  tb_val;
  assign data_bus = tb_drv ? tb_val : 8'bz;

  always #5 clk = ~clk;

  z80_io_responder #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(8), .WAIT_STATES(1), .IM2_VECTOR(8'hE0)
  ) dut (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_bus(data_bus),
    .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L),
    .WAIT_L(WAIT_L), .INT_L(INT_L),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: what the peripheral holds, in plain terms.
  logic [7:0] m_tx[$];
  logic [7:0] rd_q[$];
  bit         m_rx_avail;
  logic [7:0] m_rx;
  bit         m_ovf, m_int_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0, m_ovf, (m_int_en && m_rx_avail), (m_tx.size() == 8), m_rx_avail};
  endfunction

  task automatic check_released(input string name);
    logic       sd;
    logic [7:0] sv;
    sd = tb_drv; sv = tb_val;
    tb_drv = 1'b1; tb_val = 8'hA5; #1;
    check(name, data_bus, 8'hA5);
    tb_val = 8'h5A; #1;
    check(name, data_bus, 8'h5A);
    tb_drv = sd; tb_val = sv;
  endtask

  // Read scoreboard: the byte on the bus when WAIT_L releases must match the queued expectation.
  always @(posedge WAIT_L) begin
    if (rst_L === 1'b1 && rd_q.size() > 0 && RD_L === 1'b0) begin
      #2;
      check("read_data", data_bus, rd_q.pop_front());
    end
  end

  // TX scoreboard: head and valid follow the model; consumption is mirrored on the next edge.
  always @(negedge clk) begin
    if (rst_L === 1'b1) begin
      check("tx_valid", tx_valid, (m_tx.size() != 0));
      if (tx_valid && m_tx.size() > 0) begin
        check("tx_data", tx_data, m_tx[0]);
        if (tx_ready) void'(m_tx.pop_front());
      end
    end
  end

  task automatic io_access(input bit rd, input logic [7:0] port, input logic [7:0] wdata,
                           input bit inject, input logic [7:0] inj);
    int wl;
    bit dec;
    dec = (port[7:1] == BASE[7:1]);
    tx_ready = 1'b0;
    addr_bus = {8'($urandom_range(0, 255)), port};
    M1_L = 1'b1;
    IORQ_L = 1'b0;
    if (rd) RD_L = 1'b0;
    else begin
      WR_L = 1'b0; tb_drv = 1'b1; tb_val = wdata;
    end
    if (dec && rd) rd_q.push_back(port[0] ? m_status() : (m_rx_avail ? m_rx : 8'hFF));
    tick();
    if (!dec && rd) check_released("undecoded_bus");
    wl = 0;
    while (WAIT_L === 1'b0 && wl < 20) begin
      wl++;
      tick();
    end
    check("wait_len", wl, dec ? 1 : 0);
    if (!rd) check("wr_bus_undriven", data_bus, wdata);
    if (dec && rd && !port[0] && inject) begin
      check("rx_ready_on_pop", rx_ready, 1'b1);
      rx_valid = 1'b1; rx_data = inj;
    end
    tick();
    rx_valid = 1'b0;
    if (dec) begin
      if (rd && !port[0]) begin
        m_rx_avail = 1'b0;
        if (inject) begin m_rx = inj; m_rx_avail = 1'b1; end
      end else if (rd) begin
        m_ovf = 1'b0;
      end else if (!port[0]) begin
        if (m_tx.size() == 8) m_ovf = 1'b1;
        else m_tx.push_back(wdata);
      end else begin
        m_int_en = wdata[0];
      end
    end
    IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; tb_drv = 1'b0;
    check_released("bus_release");
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    check("rx_ready", rx_ready, !m_rx_avail);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    if (!m_rx_avail) begin m_rx = b; m_rx_avail = 1'b1; end
  endtask

  task automatic check_int();
    tick();
    check("int_l", INT_L, !(m_int_en && m_rx_avail));
  endtask

  task automatic drain(input int n);
    tx_ready = 1'b1;
    repeat (n) tick();
    tx_ready = 1'b0;
  endtask

  task automatic inta_cycle();
    IORQ_L = 1'b0; M1_L = 1'b0; RD_L = 1'b1; WR_L = 1'b1;
    tick();
    check("inta_vec", data_bus, 8'hE0);
    check("inta_no_wait", WAIT_L, 1'b1);
    tick();
    check("inta_hold_vec", data_bus, 8'hE0);
    tick();
    check("inta_hold_vec2", data_bus, 8'hE0);
    IORQ_L = 1'b1; M1_L = 1'b1;
    check_released("inta_release");
    tick();
  endtask

  initial begin
    logic [7:0] port;
    rst_L = 1'b0; addr_bus = '0; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; tb_drv = 1'b0; tb_val = '0;
    m_rx_avail = 0; m_rx = '0; m_ovf = 0; m_int_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait_l", WAIT_L, 1'b1);
    check("rst_int_l", INT_L, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check_released("rst_bus");
    rst_L = 1'b1;
    tick();

    // Single OUT to the data port
    io_access(0, BASE, 8'h5A, 0, 0);
    check("t1_tx_valid", tx_valid, 1'b1);
    check("t1_tx_data", tx_data, 8'h5A);
    drain(2);

    // Overflow: nine OUTs into an eight-deep FIFO with the device stalled
    for (int i = 0; i < 9; i++) io_access(0, BASE, 8'($urandom_range(0, 255)), 0, 0);
    io_access(1, BASE | 8'h01, 0, 0, 0);
    io_access(1, BASE | 8'h01, 0, 0, 0);
    drain(10);

    // RX byte with interrupt enabled
    io_access(0, BASE | 8'h01, 8'h01, 0, 0);
    rx_push(8'h3C);
    check_int();
    io_access(1, BASE, 0, 0, 0);
    check_int();
    check("t2_rx_ready", rx_ready, 1'b1);

    // Interrupt acknowledge leaves everything else untouched
    inta_cycle();
    io_access(1, BASE | 8'h01, 0, 0, 0);

    // Empty RX read and an undecoded port
    io_access(1, BASE, 0, 0, 0);
    io_access(1, BASE | 8'h01, 0, 0, 0);
    io_access(1, 8'h12, 0, 0, 0);
    io_access(0, 8'h12, 8'hC3, 0, 0);

    // Pop and reload in the same cycle
    rx_push(8'h11);
    io_access(1, BASE, 0, 1, 8'h22);
    io_access(1, BASE, 0, 0, 0);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: io_access(0, BASE, 8'($urandom_range(0, 255)), 0, 0);
        1: io_access(0, BASE | 8'h01, 8'($urandom_range(0, 255)), 0, 0);
        2: io_access(1, BASE, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        3: io_access(1, BASE | 8'h01, 0, 0, 0);
        4: rx_push(8'($urandom_range(0, 255)));
        5: drain($urandom_range(1, 4));
        default: begin
          port = 8'($urandom_range(0, 255));
          if (port[7:1] == BASE[7:1]) port = port ^ 8'h80;
          io_access(1'($urandom_range(0, 1)), port, 8'($urandom_range(0, 255)), 0, 0);
        end
      endcase
      check_int();
    end

    // Reset in the middle of a wait state
    io_access(0, BASE, 8'h99, 0, 0);
    addr_bus = {8'h00, BASE}; IORQ_L = 1'b0; WR_L = 1'b0; tb_drv = 1'b1; tb_val = 8'h44;
    tick();
    check("pre_rst_wait_low", WAIT_L, 1'b0);
    tb_drv = 1'b0;
    rst_L = 1'b0;
    #1;
    check("mid_rst_wait_l", WAIT_L, 1'b1);
    check_released("mid_rst_bus");
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    m_tx.delete(); rd_q.delete(); m_rx_avail = 0; m_ovf = 0; m_int_en = 0;
    IORQ_L = 1'b1; WR_L = 1'b1;
    tick();
    rst_L = 1'b1;
    tick();
    io_access(1, BASE | 8'h01, 0, 0, 0);
    io_access(0, BASE, 8'h77, 0, 0);
    rx_push(8'h5C);
    io_access(1, BASE, 0, 0, 0);
    drain(10);

    check("reads_all_seen", rd_q.size(), 0);
    check("tx_all_drained", m_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
